tmr_scrub_reg: RTL and testbench
================================

TMR_SCRUB_REG -- requirements
Module: tmr_scrub_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width per lane.
REQ-002 Parameter CNT_W, default 8: width of error counter.
REQ-003 Parameter PERSIST, default 4, legal range 2..15: consecutive mismatch cycles on one lane that declare a lane fault.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 inA, inB, inC  input  WIDTH each  triplicated data from upstream combinational stage, one per lane.
REQ-007 load  input  1  1 = capture inA/inB/inC; 0 = scrub (hold voted value).
REQ-008 clrErr  input  1  synchronous clear of errCnt, tmrErr and lane-fault state.
REQ-009 out  output  WIDTH  bitwise majority of the three lane registers.
REQ-010 tmrErr  output  1  registered flag, any lane disagreed with out in the previous cycle.
REQ-011 errCnt  output  CNT_W  saturating count of cycles with any disagreement.
REQ-012 laneFault  output  3  bit0/1/2 = lane A/B/C in FAULT state.

Function
REQ-013 Three lane registers regA, regB, regC of WIDTH bits SHALL be held.
REQ-014 load=1: regA<=inA, regB<=inB, regC<=inC independently, no cross-lane mixing.
REQ-015 load=0: all three lanes SHALL load vote(regA,regB,regC) (scrub), correcting any single-lane upset within one cycle.
REQ-016 out SHALL be combinational bitwise majority (A&B | A&C | B&C) of the lane registers; latency in->out exactly one clock when load=1.
REQ-017 Lane mismatch mX = OR-reduce(regX XOR out), evaluated each cycle for X in {A,B,C}; lanes evaluated independently, so 2 or 3 lanes may mismatch in the same cycle on different bits.
REQ-018 tmrErr SHALL be registered: next value = mA|mB|mC, one cycle after the mismatch is present on the registers.
REQ-019 errCnt SHALL increment by 1 each cycle mA|mB|mC=1, saturate at 2^CNT_W-1 without wrap.
REQ-020 clrErr=1 SHALL set errCnt, tmrErr to 0 and all lane FSMs to OK at the next edge, taking priority over any increment or transition in that cycle; lane registers and out SHALL be unaffected.
REQ-021 Each lane SHALL have an FSM {OK, SUSPECT, FAULT} with a persistence counter of 4 bits.
REQ-022 OK: mX=1 -> SUSPECT, counter=1; else stay OK, counter=0.
REQ-023 SUSPECT: mX=1 -> counter+1; when counter+1 = PERSIST -> FAULT; mX=0 -> OK, counter=0.
REQ-024 FAULT: sticky regardless of mX; exits only via clrErr or reset.
REQ-025 laneFault[i] = 1 exactly when lane i FSM is in FAULT (registered, no combinational path from inputs).
REQ-026 With load=0, a single-lane upset is corrected the next edge, so scrubbing alone never reaches FAULT; FAULT requires the upstream lane to feed bad data on PERSIST consecutive load cycles.

Reset
REQ-027 rstn=0 SHALL asynchronously clear regA/B/C, errCnt, tmrErr, laneFault and all persistence counters, set all FSMs to OK; out therefore reads 0.
REQ-028 Reset asserted mid-operation SHALL discard all state immediately; first capture after release occurs on the first edge with rstn=1 and load=1.

Verification
REQ-029 Reset, then load=1 with inA=inB=inC=0xA5 -> out=0xA5 after 1 edge, tmrErr=0, errCnt=0.
REQ-030 load=1 one cycle with inA=0xA5, inB=0xA5, inC=0x5A, then load=0 -> out=0xA5; tmrErr=1 one cycle later; errCnt=1; next cycle regC scrubbed to 0xA5, tmrErr returns to 0.
REQ-031 load=1 for 4 consecutive cycles with inB=inA^0x01, inA=inC=0x3C -> laneFault=3'b010 after 4th evaluated mismatch; errCnt=4; laneFault stays after inB corrected.
REQ-032 3 mismatch cycles on lane A then 1 clean cycle then 3 more -> laneFault=0 (persistence reset), errCnt=6.
REQ-033 CNT_W=8: 300 consecutive mismatch cycles -> errCnt holds 255; clrErr pulse concurrent with a mismatch -> errCnt=0, laneFault=0, tmrErr=0 next edge.
REQ-034 Assert rstn=0 asynchronously between edges while laneFault!=0 and errCnt=17 -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/tmr_scrub_reg.sv
// Triple-modular-redundant register with majority vote and scrubbing.
// Per-lane persistence FSMs flag lanes that keep disagreeing on load.
module tmr_scrub_reg #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 8,
   parameter int PERSIST = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [WIDTH-1:0] inC,
   input  logic             load,
   input  logic             clrErr,
   output logic [WIDTH-1:0] out,
   output logic             tmrErr,
   output logic [CNT_W-1:0] errCnt,
   output logic [2:0]       laneFault
);

   typedef enum logic [1:0] {
      OK      = 2'd0,
      SUSPECT = 2'd1,
      FAULT   = 2'd2
   } laneState_t;

   localparam logic [3:0] PERSIST_L = 4'(PERSIST);

   logic [WIDTH-1:0] regA, regB, regC;
   logic [2:0]       mis;
   logic             anyMis;
   laneState_t       st    [3];
   laneState_t       stNxt [3];
   logic [3:0]       pc    [3];
   logic [3:0]       pcNxt [3];

   assign out    = (regA & regB) | (regA & regC) | (regB & regC);
   assign mis[0] = |(regA ^ out);
   assign mis[1] = |(regB ^ out);
   assign mis[2] = |(regC ^ out);
   assign anyMis = |mis;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         regA <= '0;
         regB <= '0;
         regC <= '0;
      end else if (load) begin
         regA <= inA;
         regB <= inB;
         regC <= inC;
      end else begin
         regA <= out;
         regB <= out;
         regC <= out;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmrErr <= 1'b0;
         errCnt <= '0;
      end else if (clrErr) begin
         tmrErr <= 1'b0;
         errCnt <= '0;
      end else begin
         tmrErr <= anyMis;
         if (anyMis && (errCnt != {CNT_W{1'b1}}))
            errCnt <= errCnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 3; i++) begin
            st[i] <= OK;
            pc[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            st[i] <= stNxt[i];
            pc[i] <= pcNxt[i];
         end
      end
   end

   // FAULT is sticky; only clrErr or reset returns a lane to OK
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         stNxt[i] = st[i];
         pcNxt[i] = pc[i];
         if (clrErr) begin
            stNxt[i] = OK;
            pcNxt[i] = 4'd0;
         end else begin
            unique case (st[i])
               OK: begin
                  if (mis[i]) begin
                     stNxt[i] = SUSPECT;
                     pcNxt[i] = 4'd1;
                  end else begin
                     pcNxt[i] = 4'd0;
                  end
               end
               SUSPECT: begin
                  if (mis[i]) begin
                     pcNxt[i] = pc[i] + 4'd1;
                     if (pc[i] + 4'd1 == PERSIST_L)
                        stNxt[i] = FAULT;
                  end else begin
                     stNxt[i] = OK;
                     pcNxt[i] = 4'd0;
                  end
               end
               FAULT: begin
                  stNxt[i] = FAULT;
               end
               default: begin
                  stNxt[i] = OK;
                  pcNxt[i] = 4'd0;
               end
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++)
         laneFault[i] = (st[i] == FAULT);
   end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Directed bench for tmr_scrub_reg: voting, scrub, persistence,
// saturation, clear priority and asynchronous reset.
module tb_tmr_scrub_reg;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] inA, inB, inC;
   logic       load;
   logic       clrErr;
   logic [7:0] out;
   logic       tmrErr;
   logic [7:0] errCnt;
   logic [2:0] laneFault;

   int total = 0;
   int bad   = 0;

   tmr_scrub_reg #(
      .WIDTH   (8),
      .CNT_W   (8),
      .PERSIST (4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .inA       (inA),
      .inB       (inB),
      .inC       (inC),
      .load      (load),
      .clrErr    (clrErr),
      .out       (out),
      .tmrErr    (tmrErr),
      .errCnt    (errCnt),
      .laneFault (laneFault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rstn   = 1'b0;
      load   = 1'b0;
      clrErr = 1'b0;
      inA    = 8'h00;
      inB    = 8'h00;
      inC    = 8'h00;
      cyc(2);
      chk("rst_out", 32'(out), 32'h00);
      chk("rst_tmrErr", 32'(tmrErr), 32'h0);
      chk("rst_errCnt", 32'(errCnt), 32'h0);
      chk("rst_laneFault", 32'(laneFault), 32'h0);

      // clean capture
      rstn = 1'b1;
      load = 1'b1;
      inA  = 8'hA5;
      inB  = 8'hA5;
      inC  = 8'hA5;
      cyc(1);
      chk("cap_out", 32'(out), 32'hA5);
      chk("cap_tmrErr", 32'(tmrErr), 32'h0);
      chk("cap_errCnt", 32'(errCnt), 32'h0);

      // single-lane upset on C, then scrub
      inC = 8'h5A;
      cyc(1);
      chk("upset_out", 32'(out), 32'hA5);
      chk("upset_tmrErr0", 32'(tmrErr), 32'h0);
      load = 1'b0;
      cyc(1);
      chk("upset_tmrErr1", 32'(tmrErr), 32'h1);
      chk("upset_errCnt", 32'(errCnt), 32'h1);
      cyc(1);
      chk("scrub_tmrErr", 32'(tmrErr), 32'h0);
      chk("scrub_errCnt", 32'(errCnt), 32'h1);
      chk("scrub_out", 32'(out), 32'hA5);
      chk("scrub_laneFault", 32'(laneFault), 32'h0);

      clrErr = 1'b1;
      cyc(1);
      clrErr = 1'b0;
      chk("clr1_errCnt", 32'(errCnt), 32'h0);
      chk("clr1_out", 32'(out), 32'hA5);

      // lane B bad for 4 loads
      load = 1'b1;
      inA  = 8'h3C;
      inB  = 8'h3D;
      inC  = 8'h3C;
      cyc(4);
      chk("b4_laneFault", 32'(laneFault), 32'h0);
      chk("b4_errCnt", 32'(errCnt), 32'h3);
      inB = 8'h3C;
      cyc(1);
      chk("b5_laneFault", 32'(laneFault), 32'h2);
      chk("b5_errCnt", 32'(errCnt), 32'h4);
      cyc(1);
      chk("b6_laneFault", 32'(laneFault), 32'h2);
      chk("b6_tmrErr", 32'(tmrErr), 32'h0);
      chk("b6_errCnt", 32'(errCnt), 32'h4);

      load   = 1'b0;
      clrErr = 1'b1;
      cyc(1);
      clrErr = 1'b0;
      chk("clr2_laneFault", 32'(laneFault), 32'h0);
      chk("clr2_errCnt", 32'(errCnt), 32'h0);

      // lane A: 3 bad, 1 clean, 3 bad
      load = 1'b1;
      inA  = 8'h3D;
      cyc(3);
      inA = 8'h3C;
      cyc(1);
      inA = 8'h3D;
      cyc(3);
      inA = 8'h3C;
      cyc(2);
      chk("persist_laneFault", 32'(laneFault), 32'h0);
      chk("persist_errCnt", 32'(errCnt), 32'h6);

      clrErr = 1'b1;
      cyc(1);
      clrErr = 1'b0;

      // saturation
      inA = 8'hFF;
      cyc(300);
      chk("sat_errCnt", 32'(errCnt), 32'hFF);
      chk("sat_laneFault", 32'(laneFault), 32'h1);
      cyc(1);
      chk("sat_hold", 32'(errCnt), 32'hFF);

      // clear wins over a concurrent mismatch
      clrErr = 1'b1;
      cyc(1);
      clrErr = 1'b0;
      chk("clr3_errCnt", 32'(errCnt), 32'h0);
      chk("clr3_laneFault", 32'(laneFault), 32'h0);
      chk("clr3_tmrErr", 32'(tmrErr), 32'h0);
      chk("clr3_out", 32'(out), 32'h3C);

      // async reset between edges
      cyc(17);
      chk("pre_rst_errCnt", 32'(errCnt), 32'd17);
      chk("pre_rst_laneFault", 32'(laneFault), 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out", 32'(out), 32'h00);
      chk("arst_tmrErr", 32'(tmrErr), 32'h0);
      chk("arst_errCnt", 32'(errCnt), 32'h0);
      chk("arst_laneFault", 32'(laneFault), 32'h0);

      // first capture only after release with load=1
      cyc(1);
      rstn = 1'b1;
      load = 1'b0;
      cyc(1);
      chk("rel_scrub_out", 32'(out), 32'h00);
      load = 1'b1;
      inA  = 8'h81;
      inB  = 8'h81;
      inC  = 8'h81;
      cyc(1);
      chk("rel_cap_out", 32'(out), 32'h81);
      chk("rel_cap_errCnt", 32'(errCnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
